// File: rtl/cmd_pkg.sv
// Shared command-interface definitions: opcodes, one-hot command bit positions
// and the state set of the result return path.
package cmd_pkg;

  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_READ  = 3'b010;
  localparam logic [2:0] OP_SUM   = 3'b011;
  localparam logic [2:0] OP_AVG   = 3'b100;
  localparam logic [2:0] OP_EUC   = 3'b101;
  localparam logic [2:0] OP_MAN   = 3'b110;
  localparam logic [2:0] OP_DOT   = 3'b111;

  localparam int CMD_WRITE = 0;
  localparam int CMD_READ  = 1;
  localparam int CMD_SUM   = 2;
  localparam int CMD_AVG   = 3;
  localparam int CMD_EUC   = 4;
  localparam int CMD_MAN   = 5;
  localparam int CMD_DOT   = 6;
  localparam int CMD_W     = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_LATCH,
    TX_SEND,
    TX_GUARD,
    TX_WAIT_TX,
    TX_NEXT,
    TX_DONE
  } tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/result_tx_sequencer_byte_serializer.sv
// Streams a left-aligned word MSB byte first into a UART transmitter, one
// SEND/GUARD/WAIT_TX handshake per byte.
module byte_serializer
  import cmd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W / 8 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  n_bytes,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              ready,
  output logic              last
);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;

  assign ready = (state == TX_IDLE);
  // Final byte has left the UART this cycle; lets the sequencer move on without a bubble.
  assign last  = (state == TX_WAIT_TX) && !tx_busy && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (load) begin
            shift_q <= load_data;
            cnt_q   <= n_bytes;
            state   <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= shift_q[DATA_W-1 -: 8];
            state    <= TX_GUARD;
          end
        end
        // The UART raises tx_busy a cycle late, so it is not looked at here.
        TX_GUARD: begin
          shift_q <= shift_q << 8;
          cnt_q   <= cnt_q - 1'b1;
          state   <= TX_WAIT_TX;
        end
        TX_WAIT_TX: begin
          if (!tx_busy) state <= (cnt_q == '0) ? TX_IDLE : TX_SEND;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/result_tx_sequencer.sv
// Result return path: streams a scalar or a BRAM-resident vector to the host
// through the UART and pulses done for the command decoder.
module result_tx_sequencer
  import cmd_pkg::*;
#(
  parameter int N_ELEMS  = 1024,
  parameter int ELEM_W   = 16,
  parameter int SCALAR_W = 32,
  parameter int ADDR_W   = $clog2(N_ELEMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [SCALAR_W-1:0] scalar_in,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [ELEM_W-1:0]   rd_data,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic                tx_busy,
  output logic                busy,
  output logic                done
);

  localparam int DATA_W = max_int(ELEM_W, SCALAR_W);
  localparam int CNT_W  = $clog2(DATA_W / 8 + 1);
  localparam logic [CNT_W-1:0]  ELEM_BYTES   = CNT_W'(ELEM_W / 8);
  localparam logic [CNT_W-1:0]  SCALAR_BYTES = CNT_W'(SCALAR_W / 8);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(N_ELEMS - 1);

  tx_state_t         state;
  logic              mode_q;
  logic              accept;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0]  n_bytes;
  logic              ser_ready;
  logic              ser_last;

  assign accept = (state == TX_IDLE) && start && ser_ready;

  // Words are left-aligned so the serializer always emits from its top byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    load      = 1'b0;
    load_data = DATA_W'(rd_data) << (DATA_W - ELEM_W);
    n_bytes   = ELEM_BYTES;
    if (state == TX_IDLE) begin
      load      = accept && mode;
      load_data = DATA_W'(scalar_in) << (DATA_W - SCALAR_W);
      n_bytes   = SCALAR_BYTES;
    end else if (state == TX_LATCH) begin
      load = 1'b1;
    end
  end

  // TX_SEND here covers the whole serializer handshake for the current word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      mode_q  <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (accept) begin
            busy   <= 1'b1;
            mode_q <= mode;
            if (mode) begin
              state <= TX_SEND;
            end else begin
              rd_addr <= '0;
              rd_en   <= 1'b1;
              state   <= TX_FETCH;
            end
          end
        end
        TX_FETCH: state <= TX_LATCH;
        TX_LATCH: state <= TX_SEND;
        TX_SEND: begin
          if (ser_last) begin
            if (mode_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= TX_DONE;
            end else begin
              state <= TX_NEXT;
            end
          end
        end
        TX_NEXT: begin
          if (rd_addr == LAST_ADDR) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= TX_DONE;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            rd_en   <= 1'b1;
            state   <= TX_FETCH;
          end
        end
        TX_DONE: state <= TX_IDLE;
        default: state <= TX_IDLE;
      endcase
    end
  end

  byte_serializer #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .n_bytes   (n_bytes),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .ready     (ser_ready),
    .last      (ser_last)
  );

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Self-checking bench: UART and BRAM models plus a byte-stream reference model
// built from the scalar value or the BRAM contents.
module tb_result_tx_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [31:0] scalar_in;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data = 16'h0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        done;

  result_tx_sequencer #(
    .N_ELEMS  (N),
    .ELEM_W   (16),
    .SCALAR_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .scalar_in (scalar_in),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] mem [N];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  got_bytes [$];
  logic [1:0]  got_addrs [$];

  int cyc = 0;
  int last_start_cyc = -100;
  int fall_cyc = 0;
  int done_cyc = 0;
  int done_count = 0;
  int busy_viol = 0;
  int spacing_viol = 0;
  int stable_viol = 0;
  logic [7:0] held_byte = 8'h0;
  logic prev_busy = 1'b0;
  logic start_seen = 1'b0;
  logic rd_pend = 1'b0;
  logic [1:0] rd_pend_addr = 2'd0;
  int busy_min = 1;
  int busy_max = 4;
  int remaining = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observation point: mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    start_seen   = tx_start;
    rd_pend      = rd_en;
    rd_pend_addr = rd_addr;
    if (tx_start) begin
      got_bytes.push_back(tx_data);
      if (tx_busy) busy_viol++;
      if (cyc - last_start_cyc < 3) spacing_viol++;
      last_start_cyc = cyc;
      held_byte = tx_data;
    end else if (tx_busy && tx_data !== held_byte) begin
      stable_viol++;
    end
    if (rd_en) got_addrs.push_back(rd_addr);
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // UART model: busy from the cycle after tx_start for a random number of cycles.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      tx_busy   = 1'b0;
      remaining = 0;
    end else if (start_seen) begin
      tx_busy   = 1'b1;
      remaining = $urandom_range(busy_max, busy_min);
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) tx_busy = 1'b0;
    end
  end

  // BRAM model: data valid for exactly the one cycle after rd_en, junk otherwise.
  always @(posedge clk) begin
    #1;
    rd_data = rd_pend ? mem[rd_pend_addr] : 16'($urandom);
  end

  task automatic clear_monitors();
    got_bytes.delete();
    got_addrs.delete();
    exp_bytes.delete();
    done_count   = 0;
    busy_viol    = 0;
    spacing_viol = 0;
    stable_viol  = 0;
  endtask

  task automatic expect_scalar(input logic [31:0] s);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(8'((s >> (8 * i)) & 32'hFF));
  endtask

  task automatic expect_vector();
    for (int a = 0; a < N; a++) begin
      exp_bytes.push_back(mem[a][15:8]);
      exp_bytes.push_back(mem[a][7:0]);
    end
  endtask

  task automatic fill_mem_random();
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom);
  endtask

  task automatic pulse_start(input logic m, input logic [31:0] s);
    @(posedge clk);
    #1;
    start     = 1'b1;
    mode      = m;
    scalar_in = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (got_bytes.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_bytes_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_byte_count"}, 32'(got_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++) begin
      logic [31:0] obs;
      obs = (i < got_bytes.size()) ? 32'(got_bytes[i]) : 32'hDEAD_0000;
      check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_bytes[i]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_rd_en"},    32'(rd_en),    32'd0);
    check({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  initial begin
    logic [31:0] s;
    logic        m;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    scalar_in = '0;
    for (int a = 0; a < N; a++) mem[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Scalar DEADBEEF
    clear_monitors();
    expect_scalar(32'hDEADBEEF);
    pulse_start(1'b1, 32'hDEADBEEF);
    check("scalar_busy_after_start", 32'(busy), 32'd1);
    wait_done(400, "scalar");
    @(negedge clk);
    check("scalar_done_width", 32'(done), 32'd0);
    check("scalar_busy_after_done", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    compare_bytes("scalar");
    check("scalar_done_latency", 32'(done_cyc - fall_cyc), 32'd1);
    check("scalar_done_count", 32'(done_count), 32'd1);
    check("scalar_no_reads", 32'(got_addrs.size()), 32'd0);

    // Directed vector
    clear_monitors();
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFF00;
    expect_vector();
    pulse_start(1'b0, 32'h0);
    wait_done(800, "vector");
    repeat (2) @(posedge clk);
    #1;
    compare_bytes("vector");
    check("vector_rd_count", 32'(got_addrs.size()), 32'd4);
    for (int i = 0; i < N; i++)
      check($sformatf("vector_rd_addr%0d", i),
            (i < got_addrs.size()) ? 32'(got_addrs[i]) : 32'hFFFF_FFFF, 32'(i));
    check("vector_spacing", 32'(spacing_viol), 32'd0);
    check("vector_busy_viol", 32'(busy_viol), 32'd0);
    check("vector_done_count", 32'(done_count), 32'd1);

    // Randomised transfers, including tx_busy=1 for a single cycle
    for (int t = 0; t < 4; t++) begin
      clear_monitors();
      busy_min = 1;
      busy_max = (t == 0) ? 1 : 5;
      m = 1'($urandom_range(1, 0));
      s = $urandom;
      fill_mem_random();
      if (m) expect_scalar(s);
      else   expect_vector();
      pulse_start(m, s);
      wait_done(800, $sformatf("rand%0d", t));
      repeat (2) @(posedge clk);
      #1;
      compare_bytes($sformatf("rand%0d", t));
      check($sformatf("rand%0d_spacing", t), 32'(spacing_viol), 32'd0);
      check($sformatf("rand%0d_done_count", t), 32'(done_count), 32'd1);
    end

    // Backpressure: 50 busy cycles per byte
    clear_monitors();
    busy_min = 50;
    busy_max = 50;
    fill_mem_random();
    expect_vector();
    pulse_start(1'b0, 32'h0);
    wait_done(3000, "bp");
    repeat (2) @(posedge clk);
    #1;
    compare_bytes("bp");
    check("bp_busy_viol", 32'(busy_viol), 32'd0);
    check("bp_stable_viol", 32'(stable_viol), 32'd0);
    busy_min = 1;
    busy_max = 4;

    // Start while busy is ignored
    clear_monitors();
    fill_mem_random();
    expect_vector();
    pulse_start(1'b0, 32'h0);
    wait_bytes(3, 500, "midstart");
    pulse_start(1'b1, 32'h0BAD_F00D);
    wait_done(800, "midstart");
    repeat (20) @(posedge clk);
    #1;
    compare_bytes("midstart");
    check("midstart_done_count", 32'(done_count), 32'd1);

    // Reset during the third byte of a vector
    clear_monitors();
    fill_mem_random();
    pulse_start(1'b0, 32'h0);
    wait_bytes(3, 500, "rst");
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_monitors();
    s = $urandom;
    expect_scalar(s);
    pulse_start(1'b1, s);
    wait_done(400, "postrst");
    repeat (2) @(posedge clk);
    #1;
    compare_bytes("postrst");
    check("postrst_done_count", 32'(done_count), 32'd1);

    // Back-to-back: scalar, then vector started the cycle after done
    clear_monitors();
    s = $urandom;
    fill_mem_random();
    expect_scalar(s);
    expect_vector();
    pulse_start(1'b1, s);
    wait_done(400, "b2b_first");
    pulse_start(1'b0, 32'h0);
    wait_done(800, "b2b_second");
    repeat (2) @(posedge clk);
    #1;
    compare_bytes("b2b");
    check("b2b_done_count", 32'(done_count), 32'd2);
    check("b2b_rd_count", 32'(got_addrs.size()), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_tx_sequencer.md
Name: result_tx_sequencer

Overview:
- Return path of the command interface: after a ReadVect or a processing op completes, streams the result back to the host byte-by-byte through the UART transmitter.
- Vector results are read from BRAM element by element; scalar results (e.g. DotProd, EucDist) come from a parallel input register.
- Emits a single-cycle `done` that feeds the command decoder's op_done, so the decoder returns to WAIT.

Parameters:
- N_ELEMS, 1024, number of elements in a vector result.
- ELEM_W, 16, bits per vector element; must be a multiple of 8.
- SCALAR_W, 32, bits of scalar result; must be a multiple of 8.
- ADDR_W, $clog2(N_ELEMS), BRAM read address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a transfer.
- mode  in  1  0 = vector from BRAM, 1 = scalar from scalar_in; sampled with start.
- scalar_in  in  SCALAR_W  scalar result; sampled with start.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  ADDR_W  BRAM read address.
- rd_data  in  ELEM_W  BRAM data, valid exactly 1 cycle after rd_en.
- tx_start  out  1  one-cycle pulse: UART transmitter loads tx_data.
- tx_data  out  8  byte to transmit; held stable from tx_start until the byte completes.
- tx_busy  in  1  UART transmitter busy; goes high the cycle after tx_start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte has fully left the UART.

Behaviour:
- Reset (async): all outputs 0, state IDLE, shift register, address counter and byte counter cleared. Reset mid-transfer aborts immediately; any byte already inside the UART is not this block's concern.
- States: IDLE, FETCH, LATCH, SEND, GUARD, WAIT_TX, NEXT, DONE.
- IDLE
  - start && mode=1: load shift register with scalar_in, byte count = SCALAR_W/8, go to SEND.
  - start && mode=0: address = 0, go to FETCH.
  - start while not IDLE is ignored.
- FETCH: rd_en=1 for one cycle at rd_addr -> LATCH.
- LATCH: capture rd_data into the shift register, byte count = ELEM_W/8 -> SEND.
- SEND
  - If tx_busy=0: tx_start=1 with tx_data = shift register MSB byte -> GUARD.
  - If tx_busy=1: hold SEND, no tx_start.
- GUARD: one cycle; tx_busy is ignored here because the UART raises it late. Shift register shifts left by 8, byte count decrements -> WAIT_TX.
- WAIT_TX: wait for tx_busy=0, then:
  - byte count > 0 -> SEND;
  - byte count = 0 and mode=scalar -> DONE;
  - byte count = 0 and mode=vector -> NEXT.
- NEXT
  - rd_addr = N_ELEMS-1 -> DONE.
  - Otherwise rd_addr increments -> FETCH. No wrap-around past N_ELEMS-1.
- DONE: done=1 for exactly one cycle, busy drops -> IDLE. A start in the cycle after DONE is accepted.
- Byte order: MSB first within each element or scalar; elements in ascending address order.
- Total bytes:
  - vector: N_ELEMS*ELEM_W/8;
  - scalar: SCALAR_W/8.
- Throughput is UART-bound; the block adds at most 3 idle cycles per element boundary (NEXT, FETCH, LATCH).
- Minimum spacing between consecutive tx_start pulses is 3 cycles, even when tx_busy stays 0.

Decomposition:
- Shared package cmd_pkg holds:
  - opcode constants (3'b001 Write … 3'b111 DotProd);
  - the one-hot command bit positions (write, read, sum, avg, euc, man, dot);
  - the tx state enum for this block.
- Natural sub-module: byte_serializer.
  - Owns the shift register, byte counter and the SEND/GUARD/WAIT_TX handshake with the UART.
  - Interface: load, load_data, n_bytes, ready/last outputs.
- result_tx_sequencer keeps mode selection and BRAM address sequencing.

Test Plan:
- Scalar: mode=1, scalar_in=32'hDEADBEEF, start -> tx_data sequence DE, AD, BE, EF; exactly 4 tx_start pulses; done one cycle after tx_busy falls on the 4th byte.
- Vector (N_ELEMS=4, ELEM_W=16): BRAM = {0x1234, 0xABCD, 0x0001, 0xFF00} -> bytes 12, 34, AB, CD, 00, 01, FF, 00; rd_addr visits 0..3 once each; rd_en pulses exactly 4 times.
- Backpressure: tx_busy held high 50 cycles per byte -> never tx_start while tx_busy=1; tx_data stable throughout each byte.
- Start while busy: second start pulse mid-vector -> ignored; byte count and done count unchanged.
- Reset at byte 3 of a vector transfer -> outputs 0 same cycle; a new scalar start after reset sends a clean 4-byte sequence.
- Back-to-back: start asserted the cycle after done -> second transfer begins; no lost or duplicated bytes.
